voice_scheduler: RTL

//  Polyphonic note scheduler for the piano audio path. It maps pressed keys
//  (SW level inputs) onto NUM_VOICES phase accumulators. One shared sine

---
 rtl/voice_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: keys -> voice slots, one shared sine table, one mixed sample per FIFO slot.
// Optional build macro VOICE_STEAL_EN: a held key with no free voice steals voices round-robin.
module voice_scheduler #(
  parameter int NUM_KEYS   = 10,
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32,
  parameter int TABLE_AW   = 8,
  parameter int SAMPLE_W   = 32,
  localparam int KEY_W     = $clog2(NUM_KEYS)
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   key_on,
  output logic [KEY_W-1:0]      inc_key,
  input  logic [PHASE_W-1:0]    inc_word,
  output logic [TABLE_AW-1:0]   tbl_addr,
  input  logic [SAMPLE_W-1:0]   tbl_data,
  input  logic                  audio_out_allowed,
  output logic                  write_audio_out,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic [NUM_VOICES-1:0] voice_active
);

  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int VCNT_W  = $clog2(NUM_VOICES + 1);
  localparam logic [VCNT_W-1:0] LAST_V = VCNT_W'(NUM_VOICES);
  localparam logic [KEY_W-1:0]  LAST_K = KEY_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, VOICE, OUT} state_t;

  state_t                state_q;
  state_t                state_d;
  logic [KEY_W-1:0]      key_idx;
  logic [VCNT_W-1:0]     voice_idx;
  logic [KEY_W-1:0]      key_of [NUM_VOICES];
  logic [PHASE_W-1:0]    phase  [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] acc;
  logic                  owned;
  logic                  have_free;
  logic [VOICE_W-1:0]    owner_idx;
  logic [VOICE_W-1:0]    free_idx;
  logic [VOICE_W-1:0]    cur_v;
  logic [VOICE_W-1:0]    prev_v;
`ifdef VOICE_STEAL_EN
  logic [VOICE_W-1:0]    steal_ptr;
`endif

  assign cur_v  = voice_idx[VOICE_W-1:0];
  assign prev_v = cur_v - 1'b1;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (audio_out_allowed) state_d = SCAN;
      SCAN:    if (key_idx == LAST_K) state_d = VOICE;
      VOICE:   if (voice_idx == LAST_V) state_d = OUT;
      OUT:     if (audio_out_allowed) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Descending search so the lowest-index free voice wins.
  always_comb begin
    owned     = 1'b0;
    have_free = 1'b0;
    owner_idx = '0;
    free_idx  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (voice_active[v] && key_of[v] == key_idx) begin
        owned     = 1'b1;
        owner_idx = VOICE_W'(v);
      end
      if (!voice_active[v]) begin
        have_free = 1'b1;
        free_idx  = VOICE_W'(v);
      end
    end
  end

  always_comb begin
    tbl_addr = '0;
    inc_key  = '0;
    if (state_q == VOICE && voice_idx != LAST_V && voice_active[cur_v]) begin
      tbl_addr = phase[cur_v][PHASE_W-1 -: TABLE_AW];
      inc_key  = key_of[cur_v];
    end
  end

  // Table data lags its address by one cycle, so accumulation trails the phase step by one voice.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      voice_active    <= '0;
      key_idx         <= '0;
      voice_idx       <= '0;
      acc             <= '0;
      sample_out      <= '0;
      write_audio_out <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v]  <= '0;
        key_of[v] <= '0;
      end
`ifdef VOICE_STEAL_EN
      steal_ptr <= '0;
`endif
    end else begin
      write_audio_out <= 1'b0;
      case (state_q)
        IDLE: begin
          if (audio_out_allowed) begin
            key_idx   <= '0;
            voice_idx <= '0;
            acc       <= '0;
          end
        end
        SCAN: begin
          key_idx <= key_idx + 1'b1;
          if (!key_on[key_idx] && owned) begin
            voice_active[owner_idx] <= 1'b0;
            phase[owner_idx]        <= '0;
          end else if (key_on[key_idx] && !owned) begin
            if (have_free) begin
              voice_active[free_idx] <= 1'b1;
              key_of[free_idx]       <= key_idx;
              phase[free_idx]        <= '0;
            end
`ifdef VOICE_STEAL_EN
            else begin
              key_of[steal_ptr] <= key_idx;
              phase[steal_ptr]  <= '0;
              steal_ptr         <= steal_ptr + 1'b1;
            end
`endif
          end
        end
        VOICE: begin
          voice_idx <= voice_idx + 1'b1;
          if (voice_idx != LAST_V && voice_active[cur_v])
            phase[cur_v] <= phase[cur_v] + inc_word;
          if (voice_idx != '0 && voice_active[prev_v])
            acc <= acc + ($signed(tbl_data) >>> VOICE_W);
        end
        OUT: begin
          if (audio_out_allowed) begin
            sample_out      <= acc;
            write_audio_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
